clkdiv_multi: RTL and testbench
===============================

Name: clkdiv_multi

Overview:
- Parametrised multi-channel clock-enable/clock divider; successor to the single fixed-divisor divider.
- Each channel has a runtime-programmable period and high time, a per-period tick pulse, an enable, and a global sync restart.
- Sits between the board clock and the CPU/peripheral timing logic.
- Reprogramming is glitch-free: new settings take effect only at a period boundary.

Parameters:
- CHANNELS, 4: number of independent divider channels (1..16).
- CNT_WIDTH, 28: width of counters, divisor and high-time fields.
- DEFAULT_DIVISOR, 20000000: reset period of every channel, in clock_in cycles (≥2).

Ports:
- clock_in  in  1  system clock.
- reset_n  in  1  reset. Asynchronous assert, active-low; all state is cleared while low.
- chan_enable  in  CHANNELS  per-channel run enable.
- sync_in  in  1  one-cycle pulse; restarts all enabled channels at count 0.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  high when the single pending-config slot is empty.
- cfg_chan  in  clog2(CHANNELS) (min 1)  target channel.
- cfg_divisor  in  CNT_WIDTH  new period.
- cfg_high  in  CNT_WIDTH  new high time, in cycles.
- clock_out  out  CHANNELS  divided clock per channel.
- tick_out  out  CHANNELS  one-cycle pulse at the start of each period.

Behaviour:
- Reset (reset_n low):
  - per-channel counter = 0, divisor = DEFAULT_DIVISOR, high = DEFAULT_DIVISOR/2.
  - clock_out = 0, tick_out = 0.
  - pending slot empty, so cfg_ready = 1 as soon as reset_n is released.
- Enabled channel:
  - counter increments 0..divisor-1, then wraps to 0.
  - Registered outputs, one-cycle latency: clock_out <= (counter < high); tick_out <= (counter == 0).
  - Duty cycle = high/divisor. Example: divisor 5, high 2 gives clock_out 1,1,0,0,0 repeating.
- Disabled channel (chan_enable low):
  - counter held at 0; clock_out and tick_out forced to 0 from the next cycle.
  - When re-enabled, counting starts from 0; the first tick appears on the cycle after enable is sampled high.
- Clamping, applied when a config is committed:
  - divisor < 2 is committed as 2.
  - high > divisor is committed as divisor, giving a constant-high clock_out.
  - high = 0 gives a constant-low clock_out; tick_out still pulses each period.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready. The request is captured into the pending slot, and cfg_ready drops the next cycle.
  - cfg_valid while cfg_ready is low is ignored (no queueing).
  - The pending config commits to its channel on that channel's next wrap (counter == divisor-1), on sync_in, or on the next cycle if the channel is disabled. The pending slot then empties and cfg_ready returns high the following cycle.
  - A wrap occurring in the same cycle as the transfer does not commit the config; the next wrap does.
  - An out-of-range cfg_chan (≥ CHANNELS) is accepted and discarded; the slot empties the next cycle.
- sync_in:
  - All enabled counters load 0 (or the phase value, see Optional Feature) on the next cycle.
  - If a channel would wrap in the same cycle, sync wins.
  - Any pending config for an enabled channel commits at the sync.
- Runtime divisor shrink: never truncates the current period; the new divisor applies from count 0 of the next period.
- Arithmetic: comparisons are unsigned CNT_WIDTH. The counter never exceeds divisor-1 because every commit happens at count 0.

Optional Feature:
- Macro: CLKDIV_PHASE_EN.
- When defined:
  - extra port cfg_phase (input, CNT_WIDTH) is captured with each config.
  - a per-channel phase register is added, reset value 0.
  - on sync_in, an enabled channel's counter loads its phase instead of 0; a phase ≥ divisor is committed as divisor-1.
  - this allows fixed skew between channels.
- When undefined: no cfg_phase port and no phase registers; sync loads 0.

Decomposition:
- Package clkdiv_pkg:
  - CNT_WIDTH default value.
  - MIN_DIVISOR = 2.
  - chan_cfg_t struct: divisor, high, and phase when enabled.
  - function clamp_cfg implementing all clamping rules.
- Sub-module clkdiv_channel:
  - one counter, its committed config, enable/sync/commit inputs, and registered clock_out/tick_out.
- Top level: instantiates CHANNELS copies via generate, and contains the pending slot and handshake logic.

Test Plan:
- Reset release with DEFAULT_DIVISOR overridden to 10 and ch0 enabled -> clock_out[0] is 5 cycles high, 5 low; tick_out[0] pulses every 10 cycles; cfg_ready = 1.
- Config ch1 divisor 4, high 1 while ch1 is mid-period at divisor 10 -> old period completes unchanged; then pattern 1,0,0,0 repeating; cfg_ready low from the transfer until one cycle after commit.
- Second cfg_valid while cfg_ready is low -> ignored; only the first config takes effect.
- Clamp checks:
  - divisor 0 -> period 2.
  - high 7 with divisor 5 -> clock_out constant 1.
  - high 0 -> clock_out constant 0 with a tick every 5 cycles.
- sync_in pulse with ch0 (divisor 6) and ch2 (divisor 3) at arbitrary counts -> ticks on both channels aligned on the same cycle; sync issued on ch0's wrap cycle still restarts at 0. With CLKDIV_PHASE_EN and ch2 phase 1 -> ch2 tick occurs 2 cycles after ch0's.
- reset_n asserted mid-period with a config pending -> outputs are 0 immediately (asynchronously); after release, DEFAULT settings are in force and the pending config is lost.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Optional build macro: CLKDIV_PHASE_EN adds a per-channel sync phase field.
package clkdiv_pkg;

  // Default counter/divisor width.
  localparam int unsigned CNT_WIDTH_DEFAULT = 28;

  // Config words are carried at a fixed width and truncated inside each channel,
  // so CNT_WIDTH may be anything up to CFG_WIDTH.
  localparam int unsigned CFG_WIDTH = 32;

  // Smallest period that still produces a distinct high and low phase.
  localparam int unsigned MIN_DIVISOR = 2;

  typedef logic [CFG_WIDTH-1:0] cfg_word_t;

  typedef struct packed {
    cfg_word_t divisor;
    cfg_word_t high;
`ifdef CLKDIV_PHASE_EN
    cfg_word_t phase;
`endif
  } chan_cfg_t;

  // Bring a raw request into range: the divisor has a floor, and high time and
  // phase may not reach past the period.
  function automatic chan_cfg_t clamp_cfg(chan_cfg_t raw);
    chan_cfg_t c;
    c = raw;
    if (raw.divisor < cfg_word_t'(MIN_DIVISOR)) begin
      c.divisor = cfg_word_t'(MIN_DIVISOR);
    end
    if (raw.high > c.divisor) begin
      c.high = c.divisor;
    end
`ifdef CLKDIV_PHASE_EN
    if (raw.phase >= c.divisor) begin
      c.phase = c.divisor - cfg_word_t'(1);
    end
`endif
    return c;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, committed config and registered
// clock_out/tick_out. New config lands only when the counter restarts.
// Optional build macro: CLKDIV_PHASE_EN loads a stored phase on sync.
module clkdiv_channel import clkdiv_pkg::*; #(
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_DIVISOR = 20000000
) (
  input  logic      clock_in,
  input  logic      reset_n,
  input  logic      enable,
  input  logic      sync,
  input  logic      commit,
  input  chan_cfg_t commit_cfg,
  output logic      at_wrap,
  output logic      clock_out,
  output logic      tick_out
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] div_q;
  logic [CNT_WIDTH-1:0] high_q;
  logic [CNT_WIDTH-1:0] last_cnt;
  logic [CNT_WIDTH-1:0] sync_load;
  logic                 clock_d;
  logic                 tick_d;
  logic                 unused_cfg;

  // Config words are wider than the counter; upper bits are always zero here.
  assign unused_cfg = ^commit_cfg;

  assign last_cnt = div_q - CNT_WIDTH'(1);
  assign at_wrap  = enable && (cnt_q == last_cnt);

`ifdef CLKDIV_PHASE_EN
  logic [CNT_WIDTH-1:0] phase_q;

  // A config committed by this very sync already carries the phase to use.
  assign sync_load = commit ? commit_cfg.phase[CNT_WIDTH-1:0] : phase_q;

  // Phase register, updated alongside the rest of the committed config.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else if (commit) begin
      phase_q <= commit_cfg.phase[CNT_WIDTH-1:0];
    end
  end
`else
  assign sync_load = '0;
`endif

  // Next count and next output values; a disabled channel parks at zero.
  always_comb begin
    cnt_d   = cnt_q;
    clock_d = 1'b0;
    tick_d  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else begin
      clock_d = (cnt_q < high_q);
      tick_d  = (cnt_q == '0);
      if (sync) begin
        cnt_d = sync_load;
      end else if (cnt_q == last_cnt) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Counter, committed config and registered outputs.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      div_q     <= CNT_WIDTH'(DEFAULT_DIVISOR);
      high_q    <= CNT_WIDTH'(DEFAULT_DIVISOR / 2);
      clock_out <= 1'b0;
      tick_out  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clock_out <= clock_d;
      tick_out  <= tick_d;
      if (commit) begin
        div_q  <= commit_cfg.divisor[CNT_WIDTH-1:0];
        high_q <= commit_cfg.high[CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider top: a single pending-config slot with a
// valid/ready handshake feeding CHANNELS independent divider channels.
// Optional build macro: CLKDIV_PHASE_EN adds the cfg_phase input.
module clkdiv_multi import clkdiv_pkg::*; #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_DIVISOR = 20000000,
  localparam int unsigned CHAN_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic [CHANNELS-1:0]  chan_enable,
  input  logic                 sync_in,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [CNT_WIDTH-1:0] cfg_divisor,
  input  logic [CNT_WIDTH-1:0] cfg_high,
`ifdef CLKDIV_PHASE_EN
  input  logic [CNT_WIDTH-1:0] cfg_phase,
`endif
  output logic [CHANNELS-1:0]  clock_out,
  output logic [CHANNELS-1:0]  tick_out
);

  logic              pend_valid_q;
  logic [CHAN_W-1:0] pend_chan_q;
  chan_cfg_t         pend_cfg_q;
  chan_cfg_t         cfg_raw;
  chan_cfg_t         commit_cfg;
  logic              take;
  logic              pend_in_range;
  logic              pend_done;

  logic [CHANNELS-1:0] at_wrap;
  logic [CHANNELS-1:0] can_commit;
  logic [CHANNELS-1:0] commit;

  assign cfg_ready = ~pend_valid_q;
  assign take      = cfg_valid && cfg_ready;

  // Widen the request fields into the shared config word format.
  always_comb begin
    cfg_raw         = '0;
    cfg_raw.divisor = cfg_word_t'(cfg_divisor);
    cfg_raw.high    = cfg_word_t'(cfg_high);
`ifdef CLKDIV_PHASE_EN
    cfg_raw.phase   = cfg_word_t'(cfg_phase);
`endif
  end

  // Clamping is applied on the way out of the slot, so every channel sees a legal config.
  assign commit_cfg = clamp_cfg(pend_cfg_q);

  assign pend_in_range = (32'(pend_chan_q) < CHANNELS);

  // Out-of-range targets are simply dropped so the slot never wedges.
  assign pend_done = pend_valid_q && (!pend_in_range || (|commit));

  // Pending slot: filled on a transfer, emptied on commit or discard.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_chan_q  <= '0;
      pend_cfg_q   <= '0;
    end else if (take) begin
      pend_valid_q <= 1'b1;
      pend_chan_q  <= cfg_chan;
      pend_cfg_q   <= cfg_raw;
    end else if (pend_done) begin
      pend_valid_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    // A running channel only takes config when its counter is about to restart.
    assign can_commit[i] = chan_enable[i] ? (at_wrap[i] || sync_in) : 1'b1;
    assign commit[i]     = pend_valid_q && (pend_chan_q == CHAN_W'(i)) && can_commit[i];

    clkdiv_channel #(
      .CNT_WIDTH       (CNT_WIDTH),
      .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
    ) u_chan (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .enable     (chan_enable[i]),
      .sync       (sync_in),
      .commit     (commit[i]),
      .commit_cfg (commit_cfg),
      .at_wrap    (at_wrap[i]),
      .clock_out  (clock_out[i]),
      .tick_out   (tick_out[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi with DEFAULT_DIVISOR = 10 and four channels.
module tb_clkdiv_multi;

  logic        clock_in = 1'b0;
  logic        reset_n;
  logic [3:0]  chan_enable;
  logic        sync_in;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_chan;
  logic [27:0] cfg_divisor;
  logic [27:0] cfg_high;
`ifdef CLKDIV_PHASE_EN
  logic [27:0] cfg_phase;
`endif
  logic [3:0]  clock_out;
  logic [3:0]  tick_out;

  int n_vec = 0;
  int n_err = 0;

  logic [19:0] va, vb, vc, vd;
  logic [11:0] sa, sb, sc;

  always #5 clock_in = ~clock_in;

  clkdiv_multi #(
    .CHANNELS        (4),
    .CNT_WIDTH       (28),
    .DEFAULT_DIVISOR (10)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .chan_enable (chan_enable),
    .sync_in     (sync_in),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_divisor (cfg_divisor),
    .cfg_high    (cfg_high),
`ifdef CLKDIV_PHASE_EN
    .cfg_phase   (cfg_phase),
`endif
    .clock_out   (clock_out),
    .tick_out    (tick_out)
  );

  task automatic cyc();
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transfer one config and wait, bounded, for the slot to drain.
  task automatic send_cfg(input logic [1:0] ch, input logic [27:0] div, input logic [27:0] high);
    cfg_valid   = 1'b1;
    cfg_chan    = ch;
    cfg_divisor = div;
    cfg_high    = high;
    cyc();
    cfg_valid = 1'b0;
    for (int i = 0; i < 40 && !cfg_ready; i++) cyc();
    check("cfg_commit_wait", {31'd0, cfg_ready}, 32'd1);
  endtask

  // Program ch3 while disabled, then run it for ten cycles and disable again.
  task automatic clamp_case(input string tag, input logic [27:0] div, input logic [27:0] high,
                            input logic [9:0] exp_clk, input logic [9:0] exp_tick);
    logic [9:0] c, t;
    cfg_valid   = 1'b1;
    cfg_chan    = 2'd3;
    cfg_divisor = div;
    cfg_high    = high;
    cyc();
    check({tag, "_ready_low"}, {31'd0, cfg_ready}, 32'd0);
    cfg_valid = 1'b0;
    cyc();
    check({tag, "_ready_back"}, {31'd0, cfg_ready}, 32'd1);
    chan_enable[3] = 1'b1;
    c = '0;
    t = '0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      c = {c[8:0], clock_out[3]};
      t = {t[8:0], tick_out[3]};
    end
    check({tag, "_clock"}, {22'd0, c}, {22'd0, exp_clk});
    check({tag, "_tick"}, {22'd0, t}, {22'd0, exp_tick});
    chan_enable[3] = 1'b0;
    cyc();
    check({tag, "_off"}, {30'd0, clock_out[3], tick_out[3]}, 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    chan_enable = 4'b0001;
    sync_in     = 1'b0;
    cfg_valid   = 1'b0;
    cfg_chan    = '0;
    cfg_divisor = '0;
    cfg_high    = '0;
`ifdef CLKDIV_PHASE_EN
    cfg_phase   = '0;
`endif

    // Reset values and default 10-cycle period on ch0.
    repeat (3) @(negedge clock_in);
    check("rst_clock", {28'd0, clock_out}, 32'd0);
    check("rst_tick", {28'd0, tick_out}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    va = '0;
    vb = '0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      va = {va[18:0], clock_out[0]};
      vb = {vb[18:0], tick_out[0]};
    end
    check("ch0_default_clock", {12'd0, va}, {12'd0, 20'b11111000001111100000});
    check("ch0_default_tick", {12'd0, vb}, {12'd0, 20'b10000000001000000000});

    // Reprogram ch1 mid-period; a second request while busy must be ignored.
    chan_enable = 4'b0011;
    va = '0;
    vb = '0;
    vc = '0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      va = {va[18:0], clock_out[1]};
      vb = {vb[18:0], tick_out[1]};
      vc = {vc[18:0], cfg_ready};
      if (k == 3) begin
        cfg_valid   = 1'b1;
        cfg_chan    = 2'd1;
        cfg_divisor = 28'd4;
        cfg_high    = 28'd1;
      end
      if (k == 4) begin
        cfg_divisor = 28'd3;
        cfg_high    = 28'd2;
      end
      if (k == 5) cfg_valid = 1'b0;
    end
    check("ch1_reprog_clock", {12'd0, va}, {12'd0, 20'b11111000001000100010});
    check("ch1_reprog_tick", {12'd0, vb}, {12'd0, 20'b10000000001000100010});
    check("ch1_reprog_ready", {12'd0, vc}, {12'd0, 20'b11100000011111111111});

    // Clamping of divisor and high time.
    clamp_case("clamp_div0", 28'd0, 28'd1, 10'b1010101010, 10'b1010101010);
    clamp_case("clamp_high7", 28'd5, 28'd7, 10'b1111111111, 10'b1000010000);
    clamp_case("clamp_high0", 28'd5, 28'd0, 10'b0000000000, 10'b1000010000);

    // Sync alignment: ch0 period 6, ch2 period 3.
    send_cfg(2'd0, 28'd6, 28'd3);
    send_cfg(2'd2, 28'd3, 28'd1);
    chan_enable = 4'b0111;
    repeat (4) cyc();
    sync_in = 1'b1;
    cyc();
    sync_in = 1'b0;
    sa = '0;
    sb = '0;
    sc = '0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      sa = {sa[10:0], tick_out[0]};
      sb = {sb[10:0], tick_out[2]};
      sc = {sc[10:0], clock_out[0]};
    end
    check("sync_tick0", {20'd0, sa}, {20'd0, 12'b100000100000});
    check("sync_tick2", {20'd0, sb}, {20'd0, 12'b100100100100});
    check("sync_clock0", {20'd0, sc}, {20'd0, 12'b111000111000});

    // ch0 now sits at count 0; five cycles later it is on its wrap cycle.
    repeat (5) cyc();
    sync_in = 1'b1;
    cyc();
    sync_in = 1'b0;
    check("wrap_sync_pre", {31'd0, tick_out[0]}, 32'd0);
    cyc();
    check("wrap_sync_ticks", {30'd0, tick_out[2], tick_out[0]}, 32'd3);
    cyc();
    check("wrap_sync_post", {31'd0, tick_out[0]}, 32'd0);

`ifdef CLKDIV_PHASE_EN
    // ch2 with phase 1 ticks two cycles after ch0 following a sync.
    cfg_phase = 28'd1;
    send_cfg(2'd2, 28'd3, 28'd1);
    cfg_phase = 28'd0;
    sync_in = 1'b1;
    cyc();
    sync_in = 1'b0;
    sa = '0;
    sb = '0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      sa = {sa[10:0], tick_out[0]};
      sb = {sb[10:0], tick_out[2]};
    end
    check("phase_tick0", {20'd0, sa}, {20'd0, 12'b000000100000});
    check("phase_tick2", {20'd0, sb}, {20'd0, 12'b000000001001});
`endif

    // Reset mid-period with a config pending.
    cfg_valid   = 1'b1;
    cfg_chan    = 2'd0;
    cfg_divisor = 28'd4;
    cfg_high    = 28'd2;
    cyc();
    cfg_valid = 1'b0;
    check("pend_ready_low", {31'd0, cfg_ready}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_clock", {28'd0, clock_out}, 32'd0);
    check("async_rst_tick", {28'd0, tick_out}, 32'd0);
    check("async_rst_ready", {31'd0, cfg_ready}, 32'd1);
    chan_enable = 4'b0011;
    @(negedge clock_in);
    reset_n = 1'b1;
    va = '0;
    vb = '0;
    vc = '0;
    vd = '0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      va = {va[18:0], clock_out[0]};
      vb = {vb[18:0], tick_out[0]};
      vc = {vc[18:0], clock_out[1]};
      vd = {vd[18:0], tick_out[1]};
    end
    check("post_rst_clock0", {12'd0, va}, {12'd0, 20'b11111000001111100000});
    check("post_rst_tick0", {12'd0, vb}, {12'd0, 20'b10000000001000000000});
    check("post_rst_clock1", {12'd0, vc}, {12'd0, 20'b11111000001111100000});
    check("post_rst_tick1", {12'd0, vd}, {12'd0, 20'b10000000001000000000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
